// File: rtl/food_spawn_ctrl.sv
// food_spawn_ctrl: places new food for the two-player snake game.
// Takes food-eaten requests from both players and grants them round-robin.
// Candidate cells come from a free-running LFSR. After MAX_TRIES rejected
// random draws it switches to linear probing from the last candidate.
// Each candidate is validated against both foods, then serially against
// one slot of each snake body per cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req1, req2   level requests, held until the matching ack
//   snake1/2     MAX_LEN packed body slots, slot i at [i*NUM_LEN +: NUM_LEN]
//   food1/2      current food cells (must not be reused)
//   rand_in      LFSR value, new every cycle
//   ack1, ack2   one-cycle pulse, new_food valid for that player
//   new_food     accepted cell, held between acks
//   busy         high whenever the controller is not idle
//   linear_used  current/last placement used linear probing
module food_spawn_ctrl #(
  parameter int unsigned MAX_LEN   = 31,
  parameter int unsigned NUM_LEN   = 10,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned HEIGHT    = 24,
  parameter int unsigned MAX_TRIES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req1,
  input  logic                       req2,
  input  logic [MAX_LEN*NUM_LEN-1:0] snake1,
  input  logic [MAX_LEN*NUM_LEN-1:0] snake2,
  input  logic [NUM_LEN-1:0]         food1,
  input  logic [NUM_LEN-1:0]         food2,
  input  logic [NUM_LEN-1:0]         rand_in,
  output logic                       ack1,
  output logic                       ack2,
  output logic [NUM_LEN-1:0]         new_food,
  output logic                       busy,
  output logic                       linear_used
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [NUM_LEN:0]  CELLS_W  = (NUM_LEN+1)'(WIDTH * HEIGHT);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MAX_LEN - 1);
  localparam logic [TRY_W-1:0]  TRY_MAX  = TRY_W'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE,
    CAND,
    CHECK,
    SCAN,
    DONE
  } state_t;

  state_t             state;
  logic [NUM_LEN-1:0] cand;
  logic [IDX_W-1:0]   idx;
  logic [TRY_W-1:0]   tries;
  logic               grant_p2;  // 1: current placement is for player 2
  logic               last_p2;   // 1: player 2 was served last

  logic [NUM_LEN-1:0] s1_slot [MAX_LEN];
  logic [NUM_LEN-1:0] s2_slot [MAX_LEN];

  logic               random_mode_c;
  logic [TRY_W-1:0]   tries_inc_c;
  logic [NUM_LEN:0]   cand_inc_c;
  logic [NUM_LEN-1:0] lin_next_c;
  logic               check_rej_c;
  logic               seg_hit_c;

  // Unpack the snake buses into per-slot views.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_slot
    assign s1_slot[i] = snake1[i*NUM_LEN +: NUM_LEN];
    assign s2_slot[i] = snake2[i*NUM_LEN +: NUM_LEN];
  end

  // Candidate generation and validation terms.
  assign random_mode_c = (tries < TRY_MAX);
  assign tries_inc_c   = random_mode_c ? (tries + TRY_W'(1)) : tries;
  // One extra bit so the increment of the top index cannot wrap silently.
  assign cand_inc_c    = {1'b0, cand} + (NUM_LEN+1)'(1);
  assign lin_next_c    = (cand_inc_c >= CELLS_W) ? '0 : cand_inc_c[NUM_LEN-1:0];
  assign check_rej_c   = ({1'b0, cand} >= CELLS_W) || (cand == food1) || (cand == food2);
  assign seg_hit_c     = (s1_slot[idx] == cand) || (s2_slot[idx] == cand);

  // Placement FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ack1        <= 1'b0;
      ack2        <= 1'b0;
      new_food    <= '0;
      busy        <= 1'b0;
      linear_used <= 1'b0;
      tries       <= '0;
      idx         <= '0;
      cand        <= '0;
      grant_p2    <= 1'b0;
      last_p2     <= 1'b1;
    end else begin
      ack1 <= 1'b0;
      ack2 <= 1'b0;
      case (state)
        IDLE: begin
          if (req1 || req2) begin
            // On a tie, serve the player that was not served last.
            grant_p2    <= (req1 && req2) ? !last_p2 : req2;
            tries       <= '0;
            idx         <= '0;
            linear_used <= 1'b0;
            busy        <= 1'b1;
            state       <= CAND;
          end
        end
        CAND: begin
          if (random_mode_c) begin
            cand <= rand_in;
          end else begin
            cand        <= lin_next_c;
            linear_used <= 1'b1;
          end
          state <= CHECK;
        end
        CHECK: begin
          if (check_rej_c) begin
            tries <= tries_inc_c;
            state <= CAND;
          end else begin
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (seg_hit_c) begin
            tries <= tries_inc_c;
            state <= CAND;
          end else if (idx == LAST_IDX) begin
            // Result and ack are registered together on entry to DONE.
            new_food <= cand;
            ack1     <= !grant_p2;
            ack2     <= grant_p2;
            state    <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          last_p2 <= grant_p2;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Directed testbench for food_spawn_ctrl: latency, arbitration, rejects,
// scan hits, linear-probe wrap and asynchronous reset mid-placement.
module tb_food_spawn_ctrl;

  localparam int unsigned MAX_LEN = 31;
  localparam int unsigned NUM_LEN = 10;

  logic                       clk;
  logic                       rst_n;
  logic                       req1, req2;
  logic [MAX_LEN*NUM_LEN-1:0] snake1, snake2;
  logic [NUM_LEN-1:0]         food1, food2;
  logic [NUM_LEN-1:0]         rand_in;
  logic                       ack1, ack2;
  logic [NUM_LEN-1:0]         new_food;
  logic                       busy;
  logic                       linear_used;

  int n_tests = 0;
  int n_fail  = 0;

  // rand_in schedule: value v0, v1 from cycle sw1, v2 from cycle sw2
  int sv0, sv1, sv2, sw1, sw2;

  food_spawn_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req1        (req1),
    .req2        (req2),
    .snake1      (snake1),
    .snake2      (snake2),
    .food1       (food1),
    .food2       (food2),
    .rand_in     (rand_in),
    .ack1        (ack1),
    .ack2        (ack2),
    .new_food    (new_food),
    .busy        (busy),
    .linear_used (linear_used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_LEN-1:0] seq_at(input int n);
    if (n >= sw2)      return NUM_LEN'(sv2);
    else if (n >= sw1) return NUM_LEN'(sv1);
    else               return NUM_LEN'(sv0);
  endfunction

  task automatic set_seq(input int v0, input int s1, input int v1,
                         input int s2, input int v2);
    sv0 = v0; sw1 = s1; sv1 = v1; sw2 = s2; sv2 = v2;
  endtask

  task automatic clear_snakes();
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      snake1[i*NUM_LEN +: NUM_LEN] = 10'd1023;
      snake2[i*NUM_LEN +: NUM_LEN] = 10'd1023;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack1"}, 32'(ack1), 0);
    check({tag, "_ack2"}, 32'(ack2), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_food"}, 32'(new_food), 0);
    check({tag, "_lin"},  32'(linear_used), 0);
  endtask

  // Single-player placement; called at a negedge with the DUT idle.
  task automatic do_single(input int player, input int exp_lat, input int exp_food,
                           input int exp_lin, input string tag);
    int lat;
    int other;
    lat   = -1;
    other = 0;
    rand_in = seq_at(0);
    if (player == 1) req1 = 1'b1; else req2 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if ((player == 1 && ack2) || (player == 2 && ack1)) other++;
      if ((player == 1 && ack1) || (player == 2 && ack2)) begin
        lat = n;
        break;
      end
      rand_in = seq_at(n);
    end
    req1 = 1'b0;
    req2 = 1'b0;
    check({tag, "_lat"},  lat, exp_lat);
    check({tag, "_food"}, 32'(new_food), exp_food);
    check({tag, "_lin"},  32'(linear_used), exp_lin);
    check({tag, "_busy_done"}, 32'(busy), 1);
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 0);
    check({tag, "_ack_after"}, 32'(ack1 | ack2), 0);
    check({tag, "_other_ack"}, other, 0);
  endtask

  // Both players request in the same cycle.
  task automatic do_tie(input int first, input int food_first, input int food_second,
                        input string tag);
    int t1, t2;
    int f1, f2;
    t1 = -1; t2 = -1; f1 = -1; f2 = -1;
    rand_in = seq_at(0);
    req1 = 1'b1;
    req2 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (ack1) begin t1 = n; f1 = int'(new_food); req1 = 1'b0; end
      if (ack2) begin t2 = n; f2 = int'(new_food); req2 = 1'b0; end
      if (t1 > 0 && t2 > 0) break;
      rand_in = seq_at(n);
    end
    req1 = 1'b0;
    req2 = 1'b0;
    if (first == 1) begin
      check({tag, "_t1"}, t1, 34);
      check({tag, "_t2"}, t2, 69);
      check({tag, "_f1"}, f1, food_first);
      check({tag, "_f2"}, f2, food_second);
    end else begin
      check({tag, "_t2"}, t2, 34);
      check({tag, "_t1"}, t1, 69);
      check({tag, "_f2"}, f2, food_first);
      check({tag, "_f1"}, f1, food_second);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req1 = 1'b0;
    req2 = 1'b0;
    food1 = 10'd200;
    food2 = 10'd201;
    rand_in = 10'd0;
    clear_snakes();
    set_seq(0, 1000, 0, 1000, 0);
    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    // Plain placement for player 1
    set_seq(100, 1000, 0, 1000, 0);
    do_single(1, 34, 100, 0, "basic");

    // Reset mid-scan: everything clears at once, then a fresh placement
    set_seq(100, 1000, 0, 1000, 0);
    req1 = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    set_seq(150, 1000, 0, 1000, 0);
    do_single(1, 34, 150, 0, "rst_resume");

    // Pointer back to "player 2 served last": tie goes to player 1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_seq(123, 36, 456, 1000, 0);
    do_tie(1, 123, 456, "tie1");

    // Two CHECK rejects: out of range, then food2
    food2 = 10'd5;
    set_seq(800, 2, 5, 4, 7);
    do_single(1, 38, 7, 0, "reject");
    food2 = 10'd201;

    // Player 1 served last: tie now goes to player 2
    set_seq(50, 36, 60, 1000, 0);
    do_tie(2, 50, 60, "tie2");

    // SCAN hit on snake2 slot 20
    snake2[20*NUM_LEN +: NUM_LEN] = 10'd300;
    set_seq(300, 24, 301, 1000, 0);
    do_single(2, 57, 301, 0, "scanhit");
    clear_snakes();

    // Random draws always collide; linear probe wraps 767 -> 0
    for (int i = 0; i < int'(MAX_LEN); i++) snake1[i*NUM_LEN +: NUM_LEN] = 10'd767;
    food1 = 10'd500;
    food2 = 10'd501;
    set_seq(767, 1000, 0, 1000, 0);
    do_single(1, 82, 0, 1, "linear");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
